// File: rtl/arm_cond_pkg.sv
// ============================================================================
// Module  : arm_cond_pkg
// Brief   : ARM condition codes, CPSR flag indices, branch opcode and the
//           branch_issue state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int CPSR_N = 31;
   localparam int CPSR_Z = 30;
   localparam int CPSR_C = 29;
   localparam int CPSR_V = 28;

   localparam logic [2:0] BR_OPCODE = 3'b101;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_CPSR_REQ  = 3'd1;
   localparam logic [2:0] S_CPSR_WAIT = 3'd2;
   localparam logic [2:0] S_EVAL      = 3'd3;
   localparam logic [2:0] S_ISSUE     = 3'd4;
   localparam logic [2:0] S_SETTLE    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/arm_cond_eval.sv
// ============================================================================
// Module  : arm_cond_eval
// Brief   : Combinational ARM condition-field evaluator against NZCV.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_cond_eval
   import arm_cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = nzcv[3];
   assign w_z = nzcv[2];
   assign w_c = nzcv[1];
   assign w_v = nzcv[0];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = ~w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = ~w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = ~w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = ~w_v;
         COND_HI: pass = w_c & ~w_z;
         COND_LS: pass = ~w_c | w_z;
         COND_GE: pass = (w_n == w_v);
         COND_LT: pass = (w_n != w_v);
         COND_GT: pass = ~w_z & (w_n == w_v);
         COND_LE: pass = w_z | (w_n != w_v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_issue.sv
// ============================================================================
// Module  : branch_issue
// Brief   : B/BL decode/issue stage feeding the branch execution unit.
//           Optional macro BRANCH_ISSUE_AL_BYPASS_EN skips the CPSR read for AL.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_issue
   import arm_cond_pkg::*;
#(
   parameter int ISSUE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 12
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic        cpsr_read_en,
   input  logic [31:0] cpsr_read_value,
   output logic        br_en,
   output logic        br_cond,
   output logic        br_link,
   output logic [23:0] br_offset,
   output logic        undef,
   output logic        busy
);

   localparam logic [3:0] c_issue_last  = 4'(ISSUE_CYCLES - 1);
   localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic [31:0] r_instr;
   logic [3:0]  r_nzcv;
   logic [3:0]  r_cnt;
   logic        r_br_cond;
   logic        r_br_link;
   logic [23:0] r_br_offset;
   logic        w_transfer;
   logic        w_is_branch;
   logic        w_pass;
   logic        w_unused_cpsr;

   assign w_transfer    = instr_valid & instr_ready;
   assign w_is_branch   = (r_instr[27:25] == BR_OPCODE);
   assign w_unused_cpsr = ^cpsr_read_value[27:0];

   arm_cond_eval u_cond_eval (
      .cond (r_instr[31:28]),
      .nzcv (r_nzcv),
      .pass (w_pass)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_transfer) begin
`ifdef BRANCH_ISSUE_AL_BYPASS_EN
               w_next = (instr[31:28] == COND_AL) ? S_EVAL : S_CPSR_REQ;
`else
               w_next = S_CPSR_REQ;
`endif
            end
         end
         S_CPSR_REQ:  w_next = S_CPSR_WAIT;
         S_CPSR_WAIT: w_next = S_EVAL;
         S_EVAL:      w_next = w_is_branch ? S_ISSUE : S_IDLE;
         S_ISSUE:     if (r_cnt == c_issue_last)  w_next = S_SETTLE;
         S_SETTLE:    if (r_cnt == c_settle_last) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready  = (r_state == S_IDLE) & ~rst;
      cpsr_read_en = (r_state == S_CPSR_REQ);
      br_en        = (r_state == S_ISSUE);
      undef        = (r_state == S_EVAL) & ~w_is_branch;
      busy         = (r_state != S_IDLE);
      br_cond      = r_br_cond;
      br_link      = r_br_link;
      br_offset    = r_br_offset;
   end

   // The counter restarts on every state change, so each timed state starts at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr     <= 32'd0;
         r_nzcv      <= 4'd0;
         r_cnt       <= 4'd0;
         r_br_cond   <= 1'b0;
         r_br_link   <= 1'b0;
         r_br_offset <= 24'd0;
      end else begin
         if (w_transfer)
            r_instr <= instr;
         if (r_state == S_CPSR_WAIT)
            r_nzcv <= {cpsr_read_value[CPSR_N], cpsr_read_value[CPSR_Z],
                       cpsr_read_value[CPSR_C], cpsr_read_value[CPSR_V]};
         if (r_state == S_EVAL && w_is_branch) begin
            r_br_cond   <= w_pass;
            r_br_link   <= r_instr[24];
            r_br_offset <= r_instr[23:0];
         end
         if (w_next != r_state)
            r_cnt <= 4'd0;
         else if (r_state == S_ISSUE || r_state == S_SETTLE)
            r_cnt <= r_cnt + 4'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_issue.sv
// ============================================================================
// Module  : tb_branch_issue
// Brief   : Directed, table-driven bench for branch_issue with a small
//           register-file / branch-unit model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_issue;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] cpsr;
      logic        exp_undef;
      logic        exp_cond;
      logic        exp_link;
      logic [23:0] exp_off;
      logic        chk_pc;
      logic [31:0] pc0;
      logic [31:0] exp_pc;
      logic [31:0] exp_lr;
   } vec_t;

`ifdef BRANCH_ISSUE_AL_BYPASS_EN
   localparam bit c_bypass = 1'b1;
`else
   localparam bit c_bypass = 1'b0;
`endif
   localparam int c_issue  = 2;
   localparam int c_settle = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = 32'd0;
   logic        cpsr_read_en;
   logic [31:0] cpsr_read_value = 32'd0;
   logic        br_en, br_cond, br_link, undef, busy;
   logic [23:0] br_offset;

   logic [31:0] tb_cpsr = 32'd0;
   logic [31:0] pc = 32'd0;
   logic [31:0] lr = 32'd0;
   int          checks = 0;
   int          errors = 0;
   vec_t        vecs[$];

   branch_issue #(.ISSUE_CYCLES(c_issue), .SETTLE_CYCLES(c_settle)) dut (
      .clk             (clk),
      .rst             (rst),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .cpsr_read_en    (cpsr_read_en),
      .cpsr_read_value (cpsr_read_value),
      .br_en           (br_en),
      .br_cond         (br_cond),
      .br_link         (br_link),
      .br_offset       (br_offset),
      .undef           (undef),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Register file CPSR port: real value only in the cycle after a request.
   always @(posedge clk) cpsr_read_value <= cpsr_read_en ? tb_cpsr : ~tb_cpsr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] i, input logic [31:0] c, input logic u,
                               input logic pc_c, input logic l, input logic [23:0] off,
                               input logic cp, input logic [31:0] p0,
                               input logic [31:0] ep, input logic [31:0] el);
      vec_t v;
      v.instr = i; v.cpsr = c; v.exp_undef = u; v.exp_cond = pc_c; v.exp_link = l;
      v.exp_off = off; v.chk_pc = cp; v.pc0 = p0; v.exp_pc = ep; v.exp_lr = el;
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int          first_rd = -1, n_rd = 0, first_en = -1, n_en = 0;
      int          first_ud = -1, n_ud = 0, rdy_at = -1, wait_n = 0;
      int          lat, exp_rd;
      logic        stable_ok = 1'b1, busy_ok = 1'b1;
      logic [25:0] cap = '0;
      bit          al_fast;

      while (!instr_ready && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      chk($sformatf("v%0d_ready_in", idx), {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      instr = v.instr; tb_cpsr = v.cpsr; instr_valid = 1'b1;
      pc = v.pc0; lr = 32'd0;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
      for (int k = 0; k < 50; k++) begin
         if (cpsr_read_en) begin n_rd++; if (first_rd < 0) first_rd = k; end
         if (first_en >= 0 && {br_cond, br_link, br_offset} !== cap) stable_ok = 1'b0;
         if (br_en) begin
            if (n_en == 0) begin
               first_en = k;
               cap = {br_cond, br_link, br_offset};
               if (br_cond) begin
                  if (br_link) lr = pc + 32'd4;
                  pc = pc + 32'd8 + {{6{br_offset[23]}}, br_offset, 2'b00};
               end else
                  pc = pc + 32'd4;
            end
            n_en++;
         end
         if (undef) begin n_ud++; if (first_ud < 0) first_ud = k; end
         if (busy !== !instr_ready) busy_ok = 1'b0;
         if (instr_ready) begin rdy_at = k; break; end
         @(posedge clk); #1;
      end
      if (rdy_at < 0) chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);

      al_fast = c_bypass && (v.instr[31:28] == 4'hE);
      lat     = al_fast ? 0 : 2;
      exp_rd  = al_fast ? 0 : 1;
      chk($sformatf("v%0d_rd_cnt", idx), n_rd, exp_rd);
      if (exp_rd == 1) chk($sformatf("v%0d_rd_at", idx), first_rd, 0);
      chk($sformatf("v%0d_busy", idx), {31'd0, busy_ok}, 32'd1);
      if (v.exp_undef) begin
         chk($sformatf("v%0d_undef_cnt", idx), n_ud, 1);
         chk($sformatf("v%0d_undef_at", idx), first_ud, lat);
         chk($sformatf("v%0d_en_cnt", idx), n_en, 0);
         chk($sformatf("v%0d_ready_at", idx), rdy_at, lat + 1);
      end else begin
         chk($sformatf("v%0d_undef_cnt", idx), n_ud, 0);
         chk($sformatf("v%0d_en_cnt", idx), n_en, c_issue);
         chk($sformatf("v%0d_en_at", idx), first_en, lat + 1);
         chk($sformatf("v%0d_ready_at", idx), rdy_at, lat + 1 + c_issue + c_settle);
         chk($sformatf("v%0d_cond", idx), {31'd0, cap[25]}, {31'd0, v.exp_cond});
         chk($sformatf("v%0d_link", idx), {31'd0, cap[24]}, {31'd0, v.exp_link});
         chk($sformatf("v%0d_off", idx), {8'd0, cap[23:0]}, {8'd0, v.exp_off});
         chk($sformatf("v%0d_stable", idx), {31'd0, stable_ok}, 32'd1);
      end
      if (v.chk_pc) begin
         chk($sformatf("v%0d_pc", idx), pc, v.exp_pc);
         chk($sformatf("v%0d_lr", idx), lr, v.exp_lr);
      end
   endtask

   initial begin
      logic [15:0] masks[4];
      logic [3:0]  nz[4];
      logic [15:0] m;
      logic [3:0]  c;
      vec_t        v;
      int          n;

      // Hand-computed pass masks, bit i = condition code i passes.
      masks[0] = 16'h56AA; nz[0] = 4'h0;
      masks[1] = 16'h6655; nz[1] = 4'hF;
      masks[2] = 16'h565A; nz[2] = 4'h9;
      masks[3] = 16'h6A9A; nz[3] = 4'h8;

      vecs.push_back(mk(32'h0A00_0003, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 24'h000003,
                        1'b0, 32'd0, 32'd0, 32'd0));
      vecs.push_back(mk(32'h1A00_0003, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 24'h000003,
                        1'b1, 32'h1000, 32'h1004, 32'd0));
      vecs.push_back(mk(32'hEBFF_FFFE, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 24'hFFFFFE,
                        1'b1, 32'h2000, 32'h2000, 32'h2004));
      vecs.push_back(mk(32'hE1A0_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 24'h0,
                        1'b0, 32'd0, 32'd0, 32'd0));
      for (int ci = 0; ci < 16; ci++) begin
         for (int ni = 0; ni < 4; ni++) begin
            c = 4'(ci);
            m = masks[ni];
            vecs.push_back(mk({c, 3'b101, c[0], {6{c}}}, {nz[ni], 28'h0}, 1'b0, m[ci],
                              c[0], {6{c}}, 1'b0, 32'd0, 32'd0, 32'd0));
         end
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_outs", {26'd0, br_en, br_cond, br_link, undef, busy, cpsr_read_en}, 32'd0);
      chk("rst_off", {8'd0, br_offset}, 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rst_release_ready", {31'd0, instr_ready}, 32'd1);

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Reset asserted in the second ISSUE cycle of a BAL
      @(negedge clk);
      instr = 32'hEA00_0010; tb_cpsr = 32'd0; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      n = 0;
      while (!br_en && n < 20) begin @(posedge clk); #1; n++; end
      chk("mid_first_en", {31'd0, br_en}, 32'd1);
      @(posedge clk); #1;
      chk("mid_second_en", {31'd0, br_en}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_en", {31'd0, br_en}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("mid_release_ready", {31'd0, instr_ready}, 32'd1);
      v = mk(32'hEA00_0010, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 24'h000010,
             1'b0, 32'd0, 32'd0, 32'd0);
      run_vec(999, v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
